// File: rtl/traffic_lights.sv
// traffic_lights
//   Single-intersection traffic-light controller. A Moore FSM walks
//   RED -> YELLOW_1 -> GREEN -> YELLOW_2 -> RED forever. Each state's
//   duration comes from a 3-bit down-counter that is loaded with
//   (CYCLES - 1) whenever the state is entered.
//
//   Optional build macro: TRAFFIC_LIGHTS_RED_AMBER_EN
//     defined   : YELLOW_1 shows red+yellow (red-amber before green)
//     undefined : YELLOW_1 shows yellow only (same as YELLOW_2)
//
// Parameters
//   RED_CYCLES    (1..8) cycles spent in RED
//   YELLOW_CYCLES (1..8) cycles spent in each of YELLOW_1 and YELLOW_2
//   GREEN_CYCLES  (1..8) cycles spent in GREEN
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   red    out  red lamp
//   yellow out  yellow lamp
//   green  out  green lamp
module traffic_lights #(
  parameter int RED_CYCLES    = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int GREEN_CYCLES  = 6
) (
  input  logic clk,
  input  logic rst,
  output logic red,
  output logic yellow,
  output logic green
);

  localparam logic [3:0] S_RED      = 4'b0000;
  localparam logic [3:0] S_YELLOW_1 = 4'b0001;
  localparam logic [3:0] S_YELLOW_2 = 4'b0010;
  localparam logic [3:0] S_GREEN    = 4'b0100;

  // Load values are truncated to the 3-bit timer width, so 8 loads 7.
  localparam logic [2:0] RED_LOAD    = 3'(RED_CYCLES - 1);
  localparam logic [2:0] YELLOW_LOAD = 3'(YELLOW_CYCLES - 1);
  localparam logic [2:0] GREEN_LOAD  = 3'(GREEN_CYCLES - 1);

`ifdef TRAFFIC_LIGHTS_RED_AMBER_EN
  localparam logic Y1_RED = 1'b1;
`else
  localparam logic Y1_RED = 1'b0;
`endif

  logic [3:0] state_q, state_d;
  logic [2:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_RED: begin
        if (timer_q == 3'd0) begin
          state_d = S_YELLOW_1;
          timer_d = YELLOW_LOAD;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      S_YELLOW_1: begin
        if (timer_q == 3'd0) begin
          state_d = S_GREEN;
          timer_d = GREEN_LOAD;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      S_GREEN: begin
        if (timer_q == 3'd0) begin
          state_d = S_YELLOW_2;
          timer_d = YELLOW_LOAD;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      S_YELLOW_2: begin
        if (timer_q == 3'd0) begin
          state_d = S_RED;
          timer_d = RED_LOAD;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a full RED period regardless of timer.
        state_d = S_RED;
        timer_d = RED_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RED;
      timer_q <= RED_LOAD;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Moore decode; any illegal encoding falls through to the RED lamp set.
  always_comb begin
    red    = 1'b1;
    yellow = 1'b0;
    green  = 1'b0;
    case (state_q)
      S_YELLOW_1: begin
        red    = Y1_RED;
        yellow = 1'b1;
      end
      S_GREEN: begin
        red   = 1'b0;
        green = 1'b1;
      end
      S_YELLOW_2: begin
        red    = 1'b0;
        yellow = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_lights.sv
// tb_traffic_lights
//   Drives a default-parameter controller and an extreme-parameter one
//   (RED=1, YELLOW=1, GREEN=8) from the same clock/reset and compares
//   the lamps each cycle with a reference computed from the position
//   inside the light period since the last reset.
module tb_traffic_lights;

`ifdef TRAFFIC_LIGHTS_RED_AMBER_EN
  localparam bit RA = 1'b1;
`else
  localparam bit RA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0, y0, g0;
  logic r1, y1, g1;

  int n_assert = 0;
  int n_fail   = 0;
  int c0 = 0;
  int c1 = 0;
  bit valid = 1'b0;
  bit force_pending = 1'b0;

  always #5 clk = ~clk;

  traffic_lights u_dflt (
    .clk(clk), .rst(rst), .red(r0), .yellow(y0), .green(g0)
  );

  traffic_lights #(
    .RED_CYCLES(1), .YELLOW_CYCLES(1), .GREEN_CYCLES(8)
  ) u_ext (
    .clk(clk), .rst(rst), .red(r1), .yellow(y1), .green(g1)
  );

  // Expected {red,yellow,green} c cycles after the last reset edge.
  function automatic logic [2:0] exp_lamps(int c, int r, int y, int g);
    int p;
    int ph;
    p  = r + 2 * y + g;
    ph = c % p;
    if (ph < r)             return 3'b100;
    else if (ph < r + y)    return {RA, 1'b1, 1'b0};
    else if (ph < r + y + g) return 3'b001;
    else                    return 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dflt_lamps", {r0, y0, g0}, exp_lamps(c0, 8, 2, 6));
    chk("ext_lamps",  {r1, y1, g1}, exp_lamps(c1, 1, 1, 8));
    chk("dflt_green_excl", {1'b0, 1'b0, g0 & (r0 | y0)}, 3'b000);
    chk("ext_green_excl",  {1'b0, 1'b0, g1 & (r1 | y1)}, 3'b000);
  endtask

  // One clock: drive rst, advance the reference at the edge, check at negedge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (r) begin
      c0 = 0;
      c1 = 0;
      valid = 1'b1;
    end else begin
      c0++;
      c1++;
      if (force_pending) c0 = 0;
    end
    force_pending = 1'b0;
    @(negedge clk);
    if (valid) check_all();
  endtask

  initial begin
    @(negedge clk);

    // Reset held for two clocks, then 40 free-running clocks.
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 40; i++) step(1'b0);

    // Reset again and stop at clock 12 (mid-GREEN with defaults).
    step(1'b1);
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("mid_green_before_rst", {r0, y0, g0}, 3'b001);
    step(1'b1);
    chk("mid_green_after_rst", {r0, y0, g0}, 3'b100);
    for (int i = 0; i < 20; i++) step(1'b0);

    // Random reset pulses over a long free run.
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);

    // Illegal state injection into the default-parameter instance.
    for (int i = 0; i < 3; i++) step(1'b0);
    force u_dflt.state_q = 4'b1111;
    #1;
    chk("illegal_decode", {r0, y0, g0}, 3'b100);
    release u_dflt.state_q;
    force_pending = 1'b1;
    step(1'b0);
    chk("illegal_recover", {r0, y0, g0}, 3'b100);
    for (int i = 0; i < 25; i++) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lights.md
# traffic_lights

Single-intersection traffic-light controller that sequences a red/yellow/green lamp set through a fixed, parameter-timed cycle. It is a self-contained Moore state machine with a per-state down-counter. It sits at the leaf of the signal-control design, and its three lamp outputs drive the lamp drivers directly.

## Interface
Parameters:
- RED_CYCLES, default 8: clock cycles the RED state lasts; legal range 1..8.
- YELLOW_CYCLES, default 2: clock cycles each of YELLOW_1 and YELLOW_2 lasts; legal range 1..8.
- GREEN_CYCLES, default 6: clock cycles the GREEN state lasts; legal range 1..8.

Ports:
- One clock; reset is synchronous and active-high.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- red  output  1  red lamp on.
- yellow  output  1  yellow lamp on.
- green  output  1  green lamp on.

## Operation
- State register is 4 bits wide, with these encodings:
  - RED = 4'b0000
  - YELLOW_1 = 4'b0001 (red-to-green transition)
  - YELLOW_2 = 4'b0010 (green-to-red transition)
  - GREEN = 4'b0100
- Cycle order: RED -> YELLOW_1 -> GREEN -> YELLOW_2 -> RED, repeating forever.
- Timer is a 3-bit down-counter.
  - On entry to a state, the timer loads (that state's CYCLES - 1).
  - Each clock with the timer not 0: decrement and hold state.
  - Clock with the timer at 0: advance to the next state and load its value.
- Outputs are decoded combinationally from the state register (Moore; no input-to-output path):
  - RED: red=1, yellow=0, green=0.
  - YELLOW_1: yellow=1, green=0; red per Configuration.
  - GREEN: green=1, red=0, yellow=0.
  - YELLOW_2: yellow=1, red=0, green=0.
- green is never asserted together with red or yellow.
- Illegal state encodings: outputs decode as RED. The next clock forces state RED and loads the timer with RED_CYCLES-1.
- Timer arithmetic:
  - Parameters are truncated to 3 bits after the -1.
  - A value of 1 loads 0, giving a one-cycle state.
  - A value of 8 loads 7.

## Timing
- Reset: a rising edge with rst=1 sets state=RED and timer=RED_CYCLES-1. Outputs are red=1, yellow=0, green=0 from that edge onward.
- Reset has priority over all transitions. Asserting rst mid-cycle, in any state, returns to RED with a full RED period on the next edge.
- Before the first reset edge, the state is undefined; no guarantee is made.
- After rst deasserts, red stays on for exactly RED_CYCLES clock periods. The edge numbered RED_CYCLES after release enters YELLOW_1.
- Each state is visible for exactly its CYCLES count.
- Full period is RED_CYCLES + 2*YELLOW_CYCLES + GREEN_CYCLES clocks; 18 with the defaults.
- Output latency: lamps change on the same edge as the state, with zero added cycles.

## Configuration
- Macro TRAFFIC_LIGHTS_RED_AMBER_EN.
- Defined: in YELLOW_1, red=1 and yellow=1 (red+amber before green). YELLOW_2 is unchanged (yellow only).
- Undefined (default): in YELLOW_1, red=0 and yellow=1. Both yellow states then look identical on the outputs.
- State timing is identical in both builds.

## Test plan
- Reset: hold rst=1 for 2 clocks, then release -> red=1, yellow=0, green=0 for 8 clocks, then yellow=1 for 2, green=1 for 6, yellow=1 for 2, red=1 again at clock 18.
- Free run for 40 clocks (default parameters) -> pattern repeats with an 18-clock period. Exactly one lamp is on at all times (macro off); green never overlaps another lamp.
- Mid-GREEN reset: assert rst for 1 clock at clock 12 -> red=1 on that edge, then a full 8-clock red before yellow.
- Build with TRAFFIC_LIGHTS_RED_AMBER_EN -> red=1 and yellow=1 during the 2 YELLOW_1 clocks; YELLOW_2 shows yellow only.
- Parameter extremes: RED_CYCLES=1, YELLOW_CYCLES=1, GREEN_CYCLES=8 -> red 1 clock, yellow 1, green 8, yellow 1; period 11.
- Forced illegal state (e.g. 4'b1111 via force/release) -> outputs show red immediately. Next edge gives state RED, followed by a full RED period.
